// File: rtl/tank_pressure_sensor.sv
// Tank plant model and conditioned pressure switches PA/PB/PMB for the compressor alternator.
// Each Tick updates pressure and re-evaluates the zone; a zone must persist SETTLE Ticks before it commits.
module tank_pressure_sensor #(
    parameter int WIDTH  = 10,
    parameter int P_MAX  = 1023,
    parameter int P_INIT = 500,
    parameter int FILL   = 8,
    parameter int TH_A   = 800,
    parameter int TH_B   = 400,
    parameter int TH_MB  = 200,
    parameter int HYST   = 16,
    parameter int SETTLE = 4
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_tick,
    input  logic             i_c1,
    input  logic             i_c2,
    input  logic             i_c3,
    input  logic [3:0]       i_demand,
    output logic             o_pa,
    output logic             o_pb,
    output logic             o_pmb,
    output logic [WIDTH-1:0] o_pressure,
    output logic             o_busy
);

    localparam int SW = WIDTH + 3;
    localparam int CW = (SETTLE < 2) ? 1 : $clog2(SETTLE + 1);

    localparam logic [WIDTH-1:0] L_P_INIT  = WIDTH'(P_INIT);
    localparam logic [WIDTH-1:0] L_P_MAX   = WIDTH'(P_MAX);
    localparam logic [WIDTH-1:0] L_A_ENTER = WIDTH'(TH_A);
    localparam logic [WIDTH-1:0] L_A_EXIT  = WIDTH'(TH_A - HYST);
    localparam logic [WIDTH-1:0] L_B_ENTER = WIDTH'(TH_B);
    localparam logic [WIDTH-1:0] L_B_EXIT  = WIDTH'(TH_B + HYST);
    localparam logic [WIDTH-1:0] L_MB_ENTER = WIDTH'(TH_MB);
    localparam logic [WIDTH-1:0] L_MB_EXIT  = WIDTH'(TH_MB + HYST);

    // One-hot: bit1=HIGH, bit2=LOW, bit3=VERYLOW drive the outputs directly
    typedef enum logic [3:0] {
        Z_NORMAL  = 4'b0001,
        Z_HIGH    = 4'b0010,
        Z_LOW     = 4'b0100,
        Z_VERYLOW = 4'b1000
    } zone_t;

    logic [WIDTH-1:0] r_pressure;
    zone_t            r_zone;
    zone_t            r_prev_cand;
    logic [CW-1:0]    r_cnt;
    logic             r_busy;

    logic [1:0]       w_ncomp;
    logic [SW-1:0]    w_sum;
    logic [WIDTH-1:0] w_p_next;
    zone_t            w_cand;
    logic [CW-1:0]    w_cnt_inc;

    // Two's-complement sum in WIDTH+3 bits; MSB set means the tank would go negative
    always_comb begin
        w_ncomp = {1'b0, i_c1} + {1'b0, i_c2} + {1'b0, i_c3};
        w_sum   = {3'b000, r_pressure}
                + SW'(FILL) * {{(SW-2){1'b0}}, w_ncomp}
                - {{(SW-4){1'b0}}, i_demand};
        if (w_sum[SW-1])
            w_p_next = '0;
        else if (w_sum > {3'b000, L_P_MAX})
            w_p_next = L_P_MAX;
        else
            w_p_next = w_sum[WIDTH-1:0];
    end

    always_comb begin
        w_cand = r_zone;
        unique case (r_zone)
            Z_NORMAL: begin
                if (r_pressure >= L_A_ENTER)      w_cand = Z_HIGH;
                else if (r_pressure < L_B_ENTER)  w_cand = Z_LOW;
                else                              w_cand = Z_NORMAL;
            end
            Z_HIGH:    w_cand = (r_pressure < L_A_EXIT) ? Z_NORMAL : Z_HIGH;
            Z_LOW: begin
                if (r_pressure < L_MB_ENTER)      w_cand = Z_VERYLOW;
                else if (r_pressure >= L_B_EXIT)  w_cand = Z_NORMAL;
                else                              w_cand = Z_LOW;
            end
            Z_VERYLOW: w_cand = (r_pressure >= L_MB_EXIT) ? Z_LOW : Z_VERYLOW;
            default:   w_cand = Z_NORMAL;
        endcase
        w_cnt_inc = (w_cand != r_prev_cand) ? CW'(1) : r_cnt + CW'(1);
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_pressure  <= L_P_INIT;
            r_zone      <= Z_NORMAL;
            r_prev_cand <= Z_NORMAL;
            r_cnt       <= '0;
            r_busy      <= 1'b0;
        end else if (i_tick) begin
            r_pressure  <= w_p_next;
            r_prev_cand <= w_cand;
            if (w_cand == r_zone) begin
                r_cnt  <= '0;
                r_busy <= 1'b0;
            end else if (w_cnt_inc >= CW'(SETTLE)) begin
                r_zone <= w_cand;
                r_cnt  <= '0;
                r_busy <= 1'b0;
            end else begin
                r_cnt  <= w_cnt_inc;
                r_busy <= 1'b1;
            end
        end
    end

    assign o_pa       = r_zone[1];
    assign o_pb       = r_zone[2];
    assign o_pmb      = r_zone[3];
    assign o_pressure = r_pressure;
    assign o_busy     = r_busy;

endmodule

// File: tb/tb_tank_pressure_sensor.sv
// Scoreboarded bench: driver pushes model-predicted state per cycle, monitor pops and compares after each edge.
module tb_tank_pressure_sensor;

    logic       clk;
    logic       reset;
    logic       tick;
    logic       c1, c2, c3;
    logic [3:0] demand;
    logic       pa, pb, pmb, busy;
    logic [9:0] pressure;

    tank_pressure_sensor dut (
        .i_clk      (clk),
        .i_reset    (reset),
        .i_tick     (tick),
        .i_c1       (c1),
        .i_c2       (c2),
        .i_c3       (c3),
        .i_demand   (demand),
        .o_pa       (pa),
        .o_pb       (pb),
        .o_pmb      (pmb),
        .o_pressure (pressure),
        .o_busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int p;
        bit pa;
        bit pb;
        bit pmb;
        bit busy;
    } exp_t;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;

    // Reference model: zones 0=NORMAL 1=HIGH 2=LOW 3=VERYLOW
    int m_p, m_zone, m_pend, m_last;

    function automatic int zone_rule(input int z, input int p);
        case (z)
            0:       return (p >= 800) ? 1 : (p < 400) ? 2 : 0;
            1:       return (p < 800 - 16) ? 0 : 1;
            2:       return (p < 200) ? 3 : (p >= 400 + 16) ? 0 : 2;
            default: return (p >= 200 + 16) ? 2 : 3;
        endcase
    endfunction

    task automatic model(input bit rst, input bit tk, input int ncomp, input int dem);
        int cand;
        if (rst) begin
            m_p = 500; m_zone = 0; m_pend = 0; m_last = 0;
        end else if (tk) begin
            cand = zone_rule(m_zone, m_p);
            if (cand == m_zone)      m_pend = 0;
            else if (cand == m_last) m_pend = m_pend + 1;
            else                     m_pend = 1;
            m_last = cand;
            if (m_pend == 4) begin
                m_zone = cand;
                m_pend = 0;
            end
            m_p = m_p + 8 * ncomp - dem;
            if (m_p < 0)    m_p = 0;
            if (m_p > 1023) m_p = 1023;
        end
    endtask

    task automatic step(input bit rst, input bit tk, input bit a, input bit b, input bit c, input int dem);
        exp_t e;
        @(negedge clk);
        reset  = rst;
        tick   = tk;
        c1     = a;
        c2     = b;
        c3     = c;
        demand = 4'(dem);
        model(rst, tk, int'(a) + int'(b) + int'(c), dem);
        e.p    = m_p;
        e.pa   = (m_zone == 1);
        e.pb   = (m_zone == 2);
        e.pmb  = (m_zone == 3);
        e.busy = (m_pend != 0);
        q.push_back(e);
    endtask

    task automatic check(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, got, want);
        end
    endtask

    // Monitor: one expected state per driven cycle, compared just after the edge
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() != 0) begin
                e = q.pop_front();
                check("pressure", int'(pressure), e.p);
                check("pa",       int'(pa),       int'(e.pa));
                check("pb",       int'(pb),       int'(e.pb));
                check("pmb",      int'(pmb),      int'(e.pmb));
                check("busy",     int'(busy),     int'(e.busy));
                if (int'(pa) + int'(pb) + int'(pmb) > 1) begin
                    errors++;
                    $display("FAIL onehot at %0t: pa=%0d pb=%0d pmb=%0d", $time, pa, pb, pmb);
                end
            end
        end
    end

    initial begin
        int dir;
        bit r;
        reset = 1'b1; tick = 1'b0; c1 = 1'b0; c2 = 1'b0; c3 = 1'b0; demand = '0;
        m_p = 500; m_zone = 0; m_pend = 0; m_last = 0;

        // Reset beats Tick with all compressors on
        step(1, 1, 1, 1, 1, 0);
        step(1, 1, 1, 1, 1, 0);

        // Fill to the ceiling, then drain back out of HIGH
        for (int i = 0; i < 45; i++) step(0, 1, 1, 1, 1, 0);
        for (int i = 0; i < 45; i++) step(0, 1, 0, 0, 0, 15);

        // Drain to empty through LOW and VERYLOW, then refill slowly
        step(1, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 40; i++) step(0, 1, 0, 0, 0, 15);
        for (int i = 0; i < 3; i++)  step(0, 0, 0, 0, 0, 15);
        for (int i = 0; i < 40; i++) step(0, 1, 1, 0, 0, 0);

        // Glitch: candidate HIGH for three Ticks then back to NORMAL
        step(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 13; i++) step(0, 1, 1, 1, 1, 0);
        step(0, 1, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0, 15);
        for (int i = 0; i < 6; i++) step(0, 1, 0, 0, 0, 0);

        // Reset while a LOW change is pending
        step(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 8; i++) step(0, 1, 0, 0, 0, 15);
        step(1, 1, 0, 0, 0, 15);
        for (int i = 0; i < 6; i++) step(0, 1, 0, 0, 0, 0);

        // Randomised drift with idle cycles and occasional resets
        dir = 0;
        for (int i = 0; i < 3000; i++) begin
            if (i % 60 == 0) dir = $urandom_range(0, 2);
            r = ($urandom_range(0, 299) == 0);
            case (dir)
                0: step(r, $urandom_range(0, 3) != 0, 1, $urandom_range(0, 1) == 1,
                        $urandom_range(0, 1) == 1, $urandom_range(0, 6));
                1: step(r, $urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0, 0, 0,
                        $urandom_range(6, 15));
                default: step(r, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                        $urandom_range(0, 1) == 1, 0, $urandom_range(0, 15));
            endcase
        end

        step(0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 10 && q.size() != 0; i++) @(posedge clk);
        @(negedge clk);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expected states left unchecked, expected 0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/tank_pressure_sensor.md
Name: tank_pressure_sensor

Overview:
- Plant-side emulator and sensor conditioner that closes the loop around the compressor alternator.
- Consumes compressor run commands C1/C2/C3 and integrates a tank pressure model per Tick.
- Produces debounced, hysteretic, mutually exclusive pressure-switch signals PA (high), PB (low) and PMB (very low) for the alternator FSM.
- Used in system simulation and as the FPGA demo front end.

Parameters:
WIDTH, 10, pressure register width (bits)
P_MAX, 1023, saturation ceiling (must be ≤ 2^WIDTH-1)
P_INIT, 500, pressure after reset
FILL, 8, pressure added per running compressor per Tick
TH_A, 800, high threshold (PA)
TH_B, 400, low threshold (PB)
TH_MB, 200, very-low threshold (PMB)
HYST, 16, hysteresis band on every exit threshold
SETTLE, 4, consecutive Ticks a new zone must persist before commit (≥1)

Ports:
Clk  in  1  system clock, rising edge
Reset  in  1  synchronous, active-high reset
Tick  in  1  model-update strobe, one Clk wide
C1  in  1  compressor 1 running
C2  in  1  compressor 2 running
C3  in  1  compressor 3 running
Demand  in  4  pressure consumed per Tick (0..15)
PA  out  1  pressure high
PB  out  1  pressure low
PMB  out  1  pressure very low
Pressure  out  WIDTH  current model pressure
Busy  out  1  a zone change is pending (settle counter ≠ 0)

Behaviour:
- One clock, Clk. Reset is synchronous and active-high. Everything updates on posedge Clk only.
- Reset: Pressure=P_INIT, zone=NORMAL, settle count=0, PA=PB=PMB=0, Busy=0. Reset wins over Tick in the same cycle. Mid-operation reset discards any pending change.
- Pressure update, on a Tick cycle only:
  - P_next = P + FILL*(C1+C2+C3) − Demand.
  - Compute in WIDTH+3 bits, signed-safe.
  - Clamp to 0 if negative; clamp to P_MAX if above.
  - No wrap-around ever. Pressure is unchanged on non-Tick cycles.
- Zone FSM: states NORMAL, HIGH, LOW, VERYLOW, held one-hot internally. Outputs are direct register bits: PA=HIGH, PB=LOW, PMB=VERYLOW, NORMAL gives 000. At most one output is ever 1.
- Candidate zone is evaluated on each Tick from the registered Pressure (the value before that Tick's update):
  - NORMAL: P ≥ TH_A → HIGH; P < TH_B → LOW; else NORMAL.
  - HIGH: P < TH_A−HYST → NORMAL; else HIGH.
  - LOW: P < TH_MB → VERYLOW; P ≥ TH_B+HYST → NORMAL; else LOW.
  - VERYLOW: P ≥ TH_MB+HYST → LOW; else VERYLOW.
  - Only adjacent moves are allowed. A large jump crosses one zone per commit, then settles again.
- Settle counter:
  - On a Tick with candidate ≠ zone: count increments.
  - If candidate differs from the previous Tick's candidate, count restarts at 1.
  - On a Tick with candidate == zone: count=0.
  - When the increment would reach SETTLE: zone ← candidate and count=0 on that same edge. Outputs change at that edge.
  - Non-Tick cycles hold the count.
- Busy = (count ≠ 0), registered.
- Latency: a threshold crossing first seen at Tick k asserts the new output after the edge of Tick k+SETTLE−1.
- Simultaneous events: Pressure update and zone evaluation occur on the same Tick edge. Evaluation uses the old Pressure.

Test Plan:
1. Assert Reset for 2 cycles, with Tick=1 and C1..C3=1 → Pressure=500, PA/PB/PMB=000, Busy=0. Pressure stays 500 during Reset.
2. After reset: C1=C2=C3=1, Demand=0, Tick every cycle → Pressure +24 per Tick. Tick 14 sees 812 and sets Busy=1. PA=1 after the 17th Tick edge. PB=PMB=0 throughout.
3. Continue case 2 → Pressure clamps at 1023 and holds (no wrap), PA stays 1. Then stop compressors with Demand=15 → PA clears 4 Ticks after Pressure is first seen below 784, not at 799.
4. From 500, no compressors, Demand=15 → PB asserts, then PMB with PB deasserting on the same edge. Pressure clamps at 0. Then C1=1, Demand=0 → PMB clears to PB only after Pressure ≥216 has been seen for 4 Ticks.
5. Glitch: Pressure oscillates so the candidate is HIGH for 3 Ticks, then NORMAL → PA never asserts, count returns to 0, Busy drops.
6. Reset asserted while Busy=1 with PB pending → next cycle Pressure=500, outputs 000, Busy=0. The pending change is never committed.
